// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one memory port between N_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT timeout.
//
// state | meaning
// IDLE  | no transaction; pick the next requester round-robin from rr_ptr
// ISSUE | one-cycle gnt and mem_sel strobe towards the memory FSM
// WAIT  | hold op/addr/wdata, wait for mem_valid or the timeout
// RESP  | one-cycle done pulse, advance rr_ptr past the winner
module mem_access_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_req_we,
  input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_req_wdata,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [N_REQ-1:0]          o_done,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_err,
  output logic                      o_mem_sel,
  output logic                      o_mem_op,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  input  logic                      i_mem_valid
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_win;
  logic [7:0]        r_cnt;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_mem_sel;
  logic              r_mem_op;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [N_REQ-1:0]  w_win_oh;
  logic [N_REQ-1:0]  w_done_oh;
  logic [IDX_W-1:0]  w_next_ptr;
  logic              w_timeout;

  // Scan starting at rr_ptr; the wrap is explicit so non-power-of-two N_REQ works.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int v_idx;
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (!w_found && i_req[v_idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(v_idx);
        w_we    = i_req_we[v_idx];
        w_addr  = i_req_addr[v_idx*ADDR_W +: ADDR_W];
        w_wdata = i_req_wdata[v_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign w_win_oh   = N_REQ'(1) << w_win;
  assign w_done_oh  = N_REQ'(1) << r_win;
  assign w_next_ptr = (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + IDX_W'(1);
  assign w_timeout  = (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_sel   <= 1'b0;
      r_mem_op    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_ISSUE;
            r_win       <= w_win;
            r_gnt       <= w_win_oh;
            r_mem_sel   <= 1'b1;
            r_mem_op    <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
          end
        end
        S_ISSUE: begin
          r_gnt     <= '0;
          r_mem_sel <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // A response on the timeout cycle still counts as a good response.
          if (i_mem_valid) begin
            if (!r_mem_op) r_rdata <= i_mem_rdata;
            r_err   <= 1'b0;
            r_done  <= w_done_oh;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_done  <= w_done_oh;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_done   <= '0;
          r_cnt    <= '0;
          r_rr_ptr <= w_next_ptr;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign o_mem_sel   = r_mem_sel;
  assign o_mem_op    = r_mem_op;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
